// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial subtractor.
// Holds the slice width, the control-state encoding and the helpers used
// to derive the nibble count and validate the operand width at elaboration.
package sub_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / NIBBLE;
  endfunction

  // Operand width must be a whole, non-zero number of nibbles.
  function automatic bit width_ok(input int width);
    return ((width % NIBBLE) == 0) && (width >= NIBBLE);
  endfunction

endpackage

// File: rtl/borrow_lookahead_sub4.sv
// 4-bit borrow-lookahead subtract slice: d = x - y - bi.
// Ports:
//   x[3:0], y[3:0]  minuend / subtrahend nibble
//   bi              borrow into bit 0
//   d[3:0]          difference nibble
//   bo              borrow out of bit 3
//   b3              borrow into bit 3 (for signed-overflow detection)
module borrow_lookahead_sub4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo,
  output logic       b3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] bw;

  // g: this bit borrows on its own; p: this bit passes an incoming borrow.
  assign g = ~x & y;
  assign p = ~(x ^ y);

  // Every borrow is a flat sum of products of g/p and bi, so no term
  // waits on a lower borrow.
  assign bw[0] = bi;
  assign bw[1] = g[0] | (p[0] & bi);
  assign bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bi);
  assign bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bi);

  assign d  = x ^ y ^ bw[3:0];
  assign bo = bw[4];
  assign b3 = bw[3];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor computing (a - b - bin) mod 2^WIDTH, one nibble
// per clock, LSB nibble first, through a single borrow-lookahead slice.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only in IDLE)
//   a, b, bin             minuend, subtrahend, borrow-in
//   out_valid / out_ready result handshake (valid only in DONE)
//   diff                  difference
//   bout                  unsigned borrow-out (a < b + bin)
//   ovf                   two's-complement overflow
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NIB = nib_count(WIDTH);
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow;
  logic [KW-1:0]    k;
  logic             last;

  logic [3:0] slice_x;
  logic [3:0] slice_y;
  logic [3:0] slice_d;
  logic       slice_bo;
  logic       slice_b3;

  assign last    = (k == KW'(NIB - 1));
  assign slice_x = a_q[NIBBLE*int'(k) +: NIBBLE];
  assign slice_y = b_q[NIBBLE*int'(k) +: NIBBLE];

  borrow_lookahead_sub4 u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .bi (borrow),
    .d  (slice_d),
    .bo (slice_bo),
    .b3 (slice_b3)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture, nibble index, running borrow and result registers.
  // Results are not cleared on accept; they are overwritten nibble by
  // nibble and only meaningful once DONE is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      borrow <= 1'b0;
      k      <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            k      <= '0;
          end
        end
        BUSY: begin
          diff[NIBBLE*int'(k) +: NIBBLE] <= slice_d;
          borrow <= slice_bo;
          k      <= k + KW'(1);
          if (last) begin
            bout <= slice_bo;
            ovf  <= slice_b3 ^ slice_bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle unsigned/two's-complement subtractor that computes `a - b - bin` over WIDTH-bit operands. It processes one 4-bit nibble per clock through a borrow-lookahead slice, LSB nibble first. It is the subtract-direction companion to the team's 4-bit carry-lookahead adder and sits behind a valid/ready handshake on both sides, so datapath blocks can share one narrow slice across wide operands.

## Interface
- WIDTH, default 16: operand width in bits. It must be a multiple of 4 and at least 4. NIB = WIDTH/4.
- clk  input  1  single clock, all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  `(a - b - bin) mod 2^WIDTH`.
- bout  output  1  unsigned borrow-out: 1 iff `a < b + bin`.
- ovf  output  1  signed overflow: borrow into bit WIDTH-1 XOR borrow out of bit WIDTH-1.

## Operation
- **States**
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: both handshake outputs 0.
  - DONE: out_valid=1, in_ready=0.
- **Accept.** In IDLE, when in_valid&&in_ready:
  - capture a, b and bin into the operand registers;
  - clear the nibble index k to 0;
  - go to BUSY.
- **BUSY, each cycle:**
  - The slice computes nibble k from `a[4k+3:4k]`, `b[4k+3:4k]` and the current borrow.
  - Write the result to `diff[4k+3:4k]`.
  - Register the slice borrow-out as the next borrow.
  - Increment k.
  - When k==NIB-1, also:
    - load bout from the slice borrow-out;
    - load ovf from (slice borrow into bit 3) XOR (slice borrow-out);
    - go to DONE.
- **Slice equations.** g_i = ~x_i & y_i, p_i = ~(x_i ^ y_i), b_{i+1} = g_i | (p_i & b_i), d_i = x_i ^ y_i ^ b_i. All four borrows are flattened (lookahead), not rippled.
- **DONE.** When out_ready=1, go to IDLE. diff, bout and ovf hold until the next accept overwrites them.
- **Ignored inputs.** in_valid is ignored outside IDLE; there is no queueing. out_ready is ignored outside DONE.
- **Width rules.** Arithmetic is modulo 2^WIDTH. Operands are interpreted both unsigned (bout) and two's-complement (ovf). No saturation.
- **Reset** (asynchronous, any state, including mid-BUSY):
  - state goes to IDLE, k=0, borrow=0;
  - diff=0, bout=0, ovf=0, out_valid=0, in_ready=1;
  - any operation in flight is discarded and produces no output.

## Timing
- in_ready and out_valid are decoded directly from the state register. They are not combinational from in_valid or out_ready.
- Latency: an accept at edge T0 gives out_valid=1 after edge T0+NIB. For WIDTH=16 that is 4 cycles.
- The result is visible for at least 1 cycle. The earliest out_ready handshake is the first cycle of DONE.
- Throughput: one operation per NIB+2 cycles at best (accept cycle + NIB + DONE cycle; the next accept is in IDLE).
- Back-pressure: with out_ready=0, DONE holds indefinitely with diff/bout/ovf stable.
- diff nibbles update progressively during BUSY. Only the values present while out_valid=1 are defined.

## Structure
- Shared package `sub_pkg` holds:
  - NIBBLE=4;
  - the state enum {IDLE, BUSY, DONE};
  - function nib_count(width) returning width/NIBBLE;
  - the elaboration-time check that WIDTH%4==0 and WIDTH>=4.
- One sub-module, `borrow_lookahead_sub4`:
  - inputs x[3:0], y[3:0], bi;
  - outputs d[3:0], bo, b3 (borrow into bit 3, used for ovf);
  - purely combinational.
- The top level holds the FSM, the index counter, the operand registers and the result register.

## Test plan
All scenarios use WIDTH=16.
- a=0x1234, b=0x0234, bin=0 → diff=0x1000, bout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0; the borrow propagates across all 4 nibbles.
- a=0x8000, b=0x0001 → diff=0x7FFF, bout=0, ovf=1; and a=0x7FFF, b=0xFFFF → diff=0x8000, bout=1, ovf=1.
- a=0x0005, b=0x0005, bin=1 → diff=0xFFFF, bout=1, ovf=0.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while toggling in_valid with new operands.
  - Required response: outputs stable, in_ready=0, nothing accepted. Then out_ready=1 → IDLE next cycle, and a back-to-back accept computes correctly.
- Reset mid-operation:
  - Stimulus: drop rst_n during the second BUSY cycle.
  - Required response: immediately in_ready=1, out_valid=0, diff=0, bout=0, ovf=0. After release, a fresh 0x1234−0x0234 gives 0x1000.
